// File: rtl/debounce_pkg.sv
// Shared types and configuration helpers for the push-button debounce stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when a cnt_w-bit counter can hold the value 'cycles'.
    function automatic bit cnt_fits(input int unsigned cnt_w, input int unsigned cycles);
        return (cnt_w >= 32) || (64'(cycles) < (64'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button-in / pulse-and-level-out bundle of the debounce stage.
interface btn_debounce_pulse_if;
    logic btn_in;
    logic pulse_out;
    logic level_out;

    modport master (output btn_in, input pulse_out, input level_out);
    modport slave  (input btn_in, output pulse_out, output level_out);
endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: sync, debounce, one-cycle pulse per accepted press.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module btn_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned ACTIVE_LOW      = 0,
    parameter int unsigned REPEAT_DELAY    = 50000,
    parameter int unsigned REPEAT_PERIOD   = 10000
) (
    input logic            clk,
    input logic            rst_n,
    btn_debounce_pulse_if.slave btn_if
);

    localparam int unsigned MAX_CYCLES = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES || !cnt_fits(CNT_W, MAX_CYCLES)) begin : g_bad_cfg
        $error("btn_debounce_pulse: DEBOUNCE_CYCLES < 2 or CNT_W too narrow");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic      s_raw;
    logic      s;
    db_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic      pulse_q, pulse_d;
    logic      level_q, level_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_if.btn_in),
        .q_o   (s_raw)
    );

    assign s = (ACTIVE_LOW != 0) ? ~s_raw : s_raw;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rep_first_q selects the initial hold delay versus the steady repeat period.
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
`ifdef AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
`ifdef AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
`ifdef AUTOREPEAT_EN
                else if (rep_q == (rep_first_q ? RD_LAST : RP_LAST)) begin
                    pulse_d     = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_d = rep_q + CNT_ONE;
                end
`endif
            end
            RELEASE_WAIT: begin
                // Repeat counter is held here so a release bounce only pauses it.
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
`ifdef AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
`ifdef AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign btn_if.pulse_out = pulse_q;
    assign btn_if.level_out = level_q;

endmodule
